axi_read_router: RTL
====================

// Module: axi_read_router
// PURPOSE
//  Read-path half of the AXI interconnect, directly upstream of the default slave.
//  Arbitrates AR requests from two masters (M0 = CPU instruction port, M1 = CPU data port).
//  Decodes the address to slave S0, slave S1, or the default slave SD (index 2).
//  Routes the R beats of the granted burst back to the requesting master.
//  One read transaction is in flight at a time.
// PARAMETERS
//  ADDR_W   32            address width
//  DATA_W   32            data width
//  LEN_W    4             burst length width
//  ID_W     4             master-side ID width
//  IDS_W    8             slave-side ID width = {4-bit master tag, ID_W}
//  S0_BASE  32'h0000_0000 S0 region base; region size 64 KiB (addr[31:16] match)
//  S1_BASE  32'h0001_0000 S1 region base; region size 64 KiB
// PORTS  (m_* arrays are [2], indexed by master; s_* arrays are [3], indexed S0, S1, SD)
//  clk                                          in   1          clock
//  rst                                          in   1          reset, asynchronous, active-low
//  m_arid / m_araddr / m_arlen                  in   2x ID_W / ADDR_W / LEN_W   master AR fields
//  m_arsize / m_arburst                         in   2x3 / 2x2  master AR size / burst
//  m_arvalid                                    in   2          master AR valid
//  m_arready                                    out  2          master AR ready
//  m_rid / m_rdata / m_rresp                    out  2x ID_W / DATA_W / 2       master R fields
//  m_rlast / m_rvalid                           out  2 / 2      master R last / valid
//  m_rready                                     in   2          master R ready
//  s_arid / s_araddr / s_arlen / s_arsize / s_arburst
//                                               out  3x IDS_W / ADDR_W / LEN_W / 3 / 2   slave AR fields
//  s_arvalid                                    out  3          slave AR valid
//  s_arready                                    in   3          slave AR ready
//  s_rid / s_rdata / s_rresp / s_rlast / s_rvalid
//                                               in   3x IDS_W / DATA_W / 2 / 1 / 1       slave R fields
//  s_rready                                     out  3          slave R ready
// BEHAVIOUR
//  Reset:
//   - State IDLE; round-robin pointer selects M0 first.
//   - All m_arready, m_rvalid, s_arvalid and s_rready are 0; all data outputs are 0.
//   - Asserting rst mid-burst aborts the burst; remaining beats are not forwarded.
//  FSM states: IDLE -> ADDR -> DATA -> IDLE.
//  IDLE:
//   - No readies or valids are asserted.
//   - If any m_arvalid is high, grant the winner and go to ADDR on the next clock.
//   - Register the grant g and the decoded slave index sel.
//  Arbitration (IDLE only):
//   - Only one requester: that master wins.
//   - Both requesting: the master named by the pointer wins.
//   - After each grant, the pointer moves to the other master.
//  Address decode:
//   - araddr[31:16] == S0_BASE[31:16] selects S0.
//   - araddr[31:16] == S1_BASE[31:16] selects S1.
//   - Any other address selects SD.
//  ADDR state:
//   - s_ar*[sel] is combinational pass-through of m_ar*[g], with s_arvalid[sel] = m_arvalid[g].
//   - m_arready[g] = s_arready[sel]; every other ar valid/ready is 0.
//   - s_arid = {tag, m_arid}; tag = 4'b0001 for M0, 4'b0010 for M1.
//   - On s_arvalid & s_arready, go to DATA.
//   - Masters hold AR stable until handshake (AXI rule); a withdrawn arvalid leaves the block waiting in ADDR.
//  DATA state:
//   - m_r*[g] = s_r*[sel] with m_rid = s_rid[ID_W-1:0]; s_rready[sel] = m_rready[g].
//   - Other masters see rvalid 0; other slaves see rready 0.
//   - An internal beat counter increments on each R handshake.
//   - On an R handshake with rlast, the counter clears and the FSM goes to IDLE.
//   - New AR requests stay pending: minimum 1 idle cycle between bursts.
//  Latency: arvalid to s_arvalid = 1 cycle; R path is zero-latency (combinational).
//  No AR is issued while a burst is in DATA, so at most one read is outstanding.
// TESTING
//  1. M0 requests araddr 0x0000_0010, arlen 0
//     -> s_arvalid[0] 1 cycle later; s_arid 0x1_id; 1 beat to M0; FSM returns to IDLE.
//  2. M0 and M1 both request in the same cycle, repeated 4 times
//     -> grants M0, M1, M0, M1; the non-granted master's arready stays 0.
//  3. M1 requests araddr 0x0001_0000, arlen 3, and drops rready on beat 2 for 3 cycles
//     -> s_rready[1] drops with it; exactly 4 beats reach M1; rlast only on beat 4.
//  4. M1 requests araddr 0x1000_0000, arlen 1
//     -> routed to SD; 2 beats to M1 with rresp 2'b11 (DECERR); m_rid matches m_arid.
//  5. Assert rst during beat 2 of a 4-beat burst
//     -> all valids/readies 0 at once; IDLE; next request granted to M0 normally.

Source files
------------

// File: rtl/axi_read_router.sv
// Read-side AXI router: round-robin AR arbitration between two masters, 64 KiB
// region decode to S0/S1/default slave, and R-beat return path for one burst at a time.
`timescale 1ns/1ps

module axi_read_router #(
    parameter int              ADDR_W  = 32,
    parameter int              DATA_W  = 32,
    parameter int              LEN_W   = 4,
    parameter int              ID_W    = 4,
    parameter int              IDS_W   = 8,
    parameter logic [31:0]     S0_BASE = 32'h0000_0000,
    parameter logic [31:0]     S1_BASE = 32'h0001_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    // master AR
    input  logic [1:0][ID_W-1:0]         m_arid,
    input  logic [1:0][ADDR_W-1:0]       m_araddr,
    input  logic [1:0][LEN_W-1:0]        m_arlen,
    input  logic [1:0][2:0]              m_arsize,
    input  logic [1:0][1:0]              m_arburst,
    input  logic [1:0]                   m_arvalid,
    output logic [1:0]                   m_arready,
    // master R
    output logic [1:0][ID_W-1:0]         m_rid,
    output logic [1:0][DATA_W-1:0]       m_rdata,
    output logic [1:0][1:0]              m_rresp,
    output logic [1:0]                   m_rlast,
    output logic [1:0]                   m_rvalid,
    input  logic [1:0]                   m_rready,
    // slave AR
    output logic [2:0][IDS_W-1:0]        s_arid,
    output logic [2:0][ADDR_W-1:0]       s_araddr,
    output logic [2:0][LEN_W-1:0]        s_arlen,
    output logic [2:0][2:0]              s_arsize,
    output logic [2:0][1:0]              s_arburst,
    output logic [2:0]                   s_arvalid,
    input  logic [2:0]                   s_arready,
    // slave R
    input  logic [2:0][IDS_W-1:0]        s_rid,
    input  logic [2:0][DATA_W-1:0]       s_rdata,
    input  logic [2:0][1:0]              s_rresp,
    input  logic [2:0]                   s_rlast,
    input  logic [2:0]                   s_rvalid,
    output logic [2:0]                   s_rready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_grant;
    logic [1:0]         r_sel;
    logic               r_rr_ptr;
    logic [LEN_W-1:0]   r_beat_cnt;

    logic               w_pick;
    logic [3:0]         w_tag;
    logic               w_sel_arready;
    logic [ID_W-1:0]    w_sel_rid;
    logic [DATA_W-1:0]  w_sel_rdata;
    logic [1:0]         w_sel_rresp;
    logic               w_sel_rlast;
    logic               w_sel_rvalid;
    logic               w_ar_hs;
    logic               w_r_hs;
    logic               w_unused_rid_tag;

    // Region decode on the upper 16 address bits; anything unmapped goes to SD.
    function automatic logic [1:0] decode_slave(input logic [ADDR_W-1:0] addr);
        logic [1:0] idx;
        if (addr[ADDR_W-1:16] == S0_BASE[ADDR_W-1:16]) begin
            idx = 2'd0;
        end else if (addr[ADDR_W-1:16] == S1_BASE[ADDR_W-1:16]) begin
            idx = 2'd1;
        end else begin
            idx = 2'd2;
        end
        return idx;
    endfunction

    // Arbitration winner: a lone requester wins, otherwise the round-robin pointer decides.
    always_comb begin
        w_pick = r_rr_ptr;
        if (m_arvalid == 2'b01) begin
            w_pick = 1'b0;
        end else if (m_arvalid == 2'b10) begin
            w_pick = 1'b1;
        end else begin
            w_pick = r_rr_ptr;
        end
    end

    // Master tag prepended to the slave-side ID and the muxed view of the selected slave.
    always_comb begin
        w_tag         = 4'b0001;
        w_sel_arready = 1'b0;
        w_sel_rid     = '0;
        w_sel_rdata   = '0;
        w_sel_rresp   = 2'b00;
        w_sel_rlast   = 1'b0;
        w_sel_rvalid  = 1'b0;
        if (r_grant) begin
            w_tag = 4'b0010;
        end else begin
            w_tag = 4'b0001;
        end
        case (r_sel)
            2'd0, 2'd1, 2'd2: begin
                w_sel_arready = s_arready[r_sel];
                w_sel_rid     = s_rid[r_sel][ID_W-1:0];
                w_sel_rdata   = s_rdata[r_sel];
                w_sel_rresp   = s_rresp[r_sel];
                w_sel_rlast   = s_rlast[r_sel];
                w_sel_rvalid  = s_rvalid[r_sel];
            end
            default: begin
                w_sel_arready = 1'b0;
                w_sel_rvalid  = 1'b0;
            end
        endcase
    end

    // Slave-side tag bits are implied by the registered grant, so they are not inspected.
    always_comb begin
        w_unused_rid_tag = 1'b0;
        for (int k = 0; k < 3; k++) begin
            w_unused_rid_tag = w_unused_rid_tag ^ (^s_rid[k][IDS_W-1:ID_W]);
        end
    end

    assign w_ar_hs = (r_state == ST_ADDR) && m_arvalid[r_grant] && w_sel_arready;
    assign w_r_hs  = (r_state == ST_DATA) && w_sel_rvalid && m_rready[r_grant];

    // Transaction FSM with grant, slave select, round-robin pointer and beat count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= 1'b0;
            r_sel      <= 2'd0;
            r_rr_ptr   <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|m_arvalid) begin
                        r_grant  <= w_pick;
                        r_sel    <= decode_slave(m_araddr[w_pick]);
                        r_rr_ptr <= ~w_pick;
                        r_state  <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_ar_hs) begin
                        r_beat_cnt <= '0;
                        r_state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_r_hs) begin
                        if (w_sel_rlast) begin
                            r_beat_cnt <= '0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + {{(LEN_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Steering: only the granted master and selected slave see anything; all else is held at 0.
    always_comb begin
        s_arid    = '0;
        s_araddr  = '0;
        s_arlen   = '0;
        s_arsize  = '0;
        s_arburst = '0;
        s_arvalid = 3'b000;
        s_rready  = 3'b000;
        m_arready = 2'b00;
        m_rid     = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rlast   = 2'b00;
        m_rvalid  = 2'b00;
        for (int k = 0; k < 3; k++) begin
            if ((r_state == ST_ADDR) && (r_sel == 2'(k))) begin
                s_arid[k]    = {w_tag, m_arid[r_grant]};
                s_araddr[k]  = m_araddr[r_grant];
                s_arlen[k]   = m_arlen[r_grant];
                s_arsize[k]  = m_arsize[r_grant];
                s_arburst[k] = m_arburst[r_grant];
                s_arvalid[k] = m_arvalid[r_grant];
            end else begin
                s_arvalid[k] = 1'b0;
            end
            if ((r_state == ST_DATA) && (r_sel == 2'(k))) begin
                s_rready[k] = m_rready[r_grant];
            end else begin
                s_rready[k] = 1'b0;
            end
        end
        for (int m = 0; m < 2; m++) begin
            if ((r_state == ST_ADDR) && (r_grant == 1'(m))) begin
                m_arready[m] = w_sel_arready;
            end else begin
                m_arready[m] = 1'b0;
            end
            if ((r_state == ST_DATA) && (r_grant == 1'(m))) begin
                m_rid[m]    = w_sel_rid;
                m_rdata[m]  = w_sel_rdata;
                m_rresp[m]  = w_sel_rresp;
                m_rlast[m]  = w_sel_rlast;
                m_rvalid[m] = w_sel_rvalid;
            end else begin
                m_rvalid[m] = 1'b0;
            end
        end
    end

endmodule
